// File: rtl/cache_line_arbiter.sv
// rtl/cache_line_arbiter.sv - line-granular arbiter sharing one pmem port between I-cache and D-cache
//
// Purpose:
//   Grants one whole cache-line transaction at a time to either the
//   instruction-cache miss path or the data-cache miss/writeback path.
//   The granted request (type, address, write line) is latched at grant time.
//   It is replayed unchanged on the pmem port until pmem_resp arrives.
//   The completion is then routed to the granted requester only.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin between I and D on collision
//                       undefined -> fixed priority, data cache always wins
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_read, i_address  instruction line read request (level) and address
//   i_rdata, i_resp    returned line and one-cycle completion to I-cache
//   d_read, d_write    data line read / writeback request (level)
//   d_address, d_wdata data line address and writeback line
//   d_rdata, d_resp    returned line and one-cycle completion to D-cache
//   pmem_read/_write   downstream request, held for the whole transaction
//   pmem_address       downstream line address (latched)
//   pmem_wdata         downstream write line (latched)
//   pmem_rdata         downstream read line
//   pmem_resp          downstream one-cycle completion

module cache_line_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wdata;
    logic                    r_is_write;

    logic                    w_i_req;
    logic                    w_d_req;
    logic                    w_grant_i;
    logic                    w_grant_d;
    logic                    w_done;

    // A data request is either a line fill or a writeback; read+write together
    // is resolved as a writeback when the type is latched.
    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Completion of the in-flight transaction. pmem_resp outside a
    // transaction is deliberately ignored.
    assign w_done = (r_state != ST_IDLE) & pmem_resp;

`ifdef ARB_ROUND_ROBIN_EN
    // 1: instruction side wins the next collision, 0: data side wins.
    logic r_favour_i;

    assign w_grant_d = w_d_req & (~w_i_req | ~r_favour_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_favour_i <= 1'b0;
        end else if (w_done) begin
            // Whoever was just served yields the next collision.
            r_favour_i <= (r_state == ST_SERVE_D);
        end
    end
`else
    assign w_grant_d = w_d_req;
`endif

    assign w_grant_i = w_i_req & ~w_grant_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch: captured only on the grant edge so the downstream request
    // stays frozen even if the requester changes its inputs meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_d) begin
                r_addr     <= d_address;
                r_wdata    <= d_wdata;
                r_is_write <= d_write;
            end else if (w_grant_i) begin
                r_addr     <= i_address;
                r_wdata    <= '0;
                r_is_write <= 1'b0;
            end
        end
    end

    // Next-state and transaction outputs. Outputs decode from the state
    // register so an asynchronous reset drops the pmem request at once.
    always_comb begin
        w_next_state = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = ST_SERVE_D;
                end else if (w_grant_i) begin
                    w_next_state = ST_SERVE_I;
                end
            end
            ST_SERVE_I: begin
                pmem_read = 1'b1;
                i_resp    = pmem_resp;
                if (pmem_resp) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SERVE_D: begin
                pmem_read  = ~r_is_write;
                pmem_write = r_is_write;
                d_resp     = pmem_resp;
                if (pmem_resp) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;

    // Read data is broadcast; only the resp pulse qualifies it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: doc/cache_line_arbiter.md
# cache_line_arbiter

Sequences a single shared physical-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core. The block sits below the two L1 caches and above the L2/physical memory. It grants one whole cache-line transaction at a time, holds the downstream request stable until memory responds, and returns the response to the granted requester only. Arbitration is fixed-priority or round-robin, selected at compile time.

## Interface
- ADDR_WIDTH, 32, byte address width of all ports
- LINE_WIDTH, 256, cache line width in bits
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_read  in  1  instruction-cache line read request; level, held until i_resp
- i_address  in  ADDR_WIDTH  instruction line address
- i_rdata  out  LINE_WIDTH  line returned to instruction cache
- i_resp  out  1  one-cycle completion pulse to instruction cache
- d_read  in  1  data-cache line read request; level, held until d_resp
- d_write  in  1  data-cache line writeback request; level, held until d_resp
- d_address  in  ADDR_WIDTH  data line address
- d_wdata  in  LINE_WIDTH  writeback line
- d_rdata  out  LINE_WIDTH  line returned to data cache
- d_resp  out  1  one-cycle completion pulse to data cache
- pmem_read  out  1  downstream read request
- pmem_write  out  1  downstream write request
- pmem_address  out  ADDR_WIDTH  downstream line address
- pmem_wdata  out  LINE_WIDTH  downstream write line
- pmem_rdata  in  LINE_WIDTH  downstream read line
- pmem_resp  in  1  downstream completion, one cycle

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: no pmem request. If any request is present, pick a winner (see Configuration), latch its address (and d_wdata, read/write type) into internal registers, move to SERVE_I or SERVE_D.
- SERVE_x: pmem_read/pmem_write, pmem_address, pmem_wdata driven from the latched registers; constant for the whole transaction regardless of requester inputs.
- On pmem_resp in SERVE_x: assert the granted requester's resp in the same cycle; present pmem_rdata on its rdata; return to IDLE on that edge.
- Non-granted requester's resp is 0 throughout; its request stays pending and is arbitrated in the next IDLE.
- i_rdata and d_rdata are both driven with pmem_rdata at all times; only the resp pulses qualify them.
- d_read and d_write both high: treated as a write.
- pmem_resp in IDLE: ignored; no resp pulse.
- Requesters drop the request in the cycle after their resp; the one-cycle IDLE gap guarantees no double grant.

## Timing
- Reset: state IDLE; pmem_read, pmem_write, i_resp, d_resp = 0; latched address/wdata = 0; round-robin pointer favours data. Reset assertion mid-transaction drops pmem_read/pmem_write immediately (asynchronous); the in-flight transaction is abandoned and no resp is issued.
- Grant latency: request seen in IDLE at edge N -> pmem_read/write high from edge N (cycle N+1).
- Response latency: pmem_resp -> requester resp in the same cycle (combinational).
- Minimum transaction: 2 cycles (grant cycle + resp cycle), then one IDLE cycle before the next grant.
- Back-to-back: two pending requesters are served consecutively with exactly one IDLE cycle between them.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a one-bit priority pointer is kept. When both requesters are pending in IDLE, the pointer picks the winner. After each completed transaction, the pointer flips to favour the other requester.
- Undefined: fixed priority. Data cache always wins when both are pending. No pointer register exists.

## Test plan
- Lone i_read, i_address=0x0000_1000; memory responds 3 cycles after pmem_read -> pmem_read=1, pmem_address=0x1000; i_resp pulses 1 cycle with i_rdata=pmem_rdata; d_resp stays 0.
- d_write, d_address=0x0000_2040, d_wdata=all 0xA5 -> pmem_write=1 with identical address and data; d_resp pulses once; inputs changed mid-transaction do not alter pmem_address or pmem_wdata.
- i_read and d_read rise together, default build -> data served first, then i_read after one IDLE cycle. With ARB_ROUND_ROBIN_EN, after one prior data transaction, a repeat collision grants instruction first.
- Continuous saturated requests from both for 8 transactions with ARB_ROUND_ROBIN_EN -> strict alternation I/D, 4 grants each.
- rst_n low while SERVE_D with pmem_write=1 -> pmem_write falls without waiting for a clock edge; no d_resp. After release, a still-held d_write is re-granted from IDLE.
- pmem_resp pulsed while IDLE -> no i_resp or d_resp; state stays IDLE.
